pipe_hazard_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage RISC-V pipeline. Each cycle it decides whether each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) advances, holds or is flushed to a bubble, and whether the PC loads the branch target. It handles three cases: load-use hazards in ID, taken branches resolved from EX/MEM outputs, and multi-cycle data-memory waits. It also tracks its own state and runs a memory-wait timeout.

---
 rtl/pipe_ctrl_pkg.sv | 74 +++++++
 rtl/pipe_wait_timer.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: state encoding, the pipeline bubble,
// and the per-action control pattern for the pipeline-register enables and flushes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_e;

    localparam int unsigned MEM_TIMEOUT_DEF = 64;

    // Control word carried by the pipeline registers; a bubble has every control deasserted.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_BUBBLE = '0;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic if_id_fl;
        logic id_ex_fl;
        logic ex_mem_fl;
        logic mem_wb_fl;
        logic pc_src;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_CTRL_RESET = '{
        pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0, ex_mem_we: 1'b0,
        if_id_fl: 1'b1, id_ex_fl: 1'b1, ex_mem_fl: 1'b1, mem_wb_fl: 1'b1,
        pc_src: 1'b0
    };

    function automatic hz_ctrl_t hz_ctrl_for(hz_state_e act);
        hz_ctrl_t c;
        c = '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1, ex_mem_we: 1'b1,
              if_id_fl: 1'b0, id_ex_fl: 1'b0, ex_mem_fl: 1'b0, mem_wb_fl: 1'b0,
              pc_src: 1'b0};
        case (act)
            ST_MEM_WAIT: begin
                c.pc_we     = 1'b0;
                c.if_id_we  = 1'b0;
                c.id_ex_we  = 1'b0;
                c.ex_mem_we = 1'b0;
                c.mem_wb_fl = 1'b1;
            end
            ST_BR_FLUSH: begin
                c.pc_src    = 1'b1;
                c.if_id_fl  = 1'b1;
                c.id_ex_fl  = 1'b1;
                c.ex_mem_fl = 1'b1;
            end
            ST_LD_STALL: begin
                c.pc_we    = 1'b0;
                c.if_id_we = 1'b0;
                c.id_ex_fl = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_wait_timer.sv
// Consecutive memory-stall counter, saturating at MEM_TIMEOUT, with a sticky timeout flag.
module pipe_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    output logic err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (stall) begin
            if (cnt != CNT_W'(MEM_TIMEOUT)) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Flag on the edge where the count reaches the limit.
            if (cnt >= CNT_W'(MEM_TIMEOUT - 1)) begin
                err <= 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use stalls, taken-branch flushes, memory waits.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              mem_branch,
    input  logic              mem_z_flag,
    input  logic              mem_access,
    input  logic              dmem_ready,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              id_ex_write_en,
    output logic              ex_mem_write_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              pc_src_branch,
    output logic              mem_timeout_err,
    output logic [1:0]        state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] branch_flushes
`endif
);

    // An illegal parameter set falls back to the smallest legal timeout.
    localparam int unsigned TIMEOUT = (MEM_TIMEOUT >= 2 && PERF_W >= 1) ? MEM_TIMEOUT : 2;

    hz_state_e state_q;
    hz_state_e act;
    hz_ctrl_t  ctrl;
    logic      load_use;
    logic      branch_taken;
    logic      mem_stall;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign branch_taken = mem_branch & mem_z_flag;
    assign mem_stall    = mem_access & ~dmem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= act;
        end
    end

    // Held registers during a memory wait re-present any branch/load-use afterwards.
    always_comb begin
        act = ST_RUN;
        if (mem_stall) begin
            act = ST_MEM_WAIT;
        end else if (branch_taken) begin
            act = ST_BR_FLUSH;
        end else if (load_use && (state_q != ST_LD_STALL)) begin
            act = ST_LD_STALL;
        end
        ctrl = reset ? HZ_CTRL_RESET : hz_ctrl_for(act);
    end

    assign pc_write_en     = ctrl.pc_we;
    assign if_id_write_en  = ctrl.if_id_we;
    assign id_ex_write_en  = ctrl.id_ex_we;
    assign ex_mem_write_en = ctrl.ex_mem_we;
    assign if_id_flush     = ctrl.if_id_fl;
    assign id_ex_flush     = ctrl.id_ex_fl;
    assign ex_mem_flush    = ctrl.ex_mem_fl;
    assign mem_wb_flush    = ctrl.mem_wb_fl;
    assign pc_src_branch   = ctrl.pc_src;
    assign state           = state_q;

    pipe_wait_timer #(
        .MEM_TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk  (clk),
        .reset(reset),
        .stall(mem_stall),
        .err  (mem_timeout_err)
    );

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles   <= '0;
            branch_flushes <= '0;
        end else begin
            if ((act == ST_MEM_WAIT) || (act == ST_LD_STALL)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
            if (act == ST_BR_FLUSH) begin
                branch_flushes <= branch_flushes + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed literal checks plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MT = 4;
    localparam int PW = 8;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read;
    logic        mem_branch, mem_z_flag, mem_access, dmem_ready;
    logic        pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        pc_src_branch, mem_timeout_err;
    logic [1:0]  state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [PW-1:0] stall_cycles, branch_flushes;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_branch(mem_branch), .mem_z_flag(mem_z_flag),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .pc_src_branch(pc_src_branch), .mem_timeout_err(mem_timeout_err),
        .state(state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .stall_cycles(stall_cycles), .branch_flushes(branch_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, pc_src}
    logic [8:0] dut_vec;
    assign dut_vec = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
                      if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_src_branch};

    localparam logic [8:0] V_RESET = 9'b0000_1111_0;
    localparam logic [8:0] V_RUN   = 9'b1111_0000_0;
    localparam logic [8:0] V_LD    = 9'b0011_0100_0;
    localparam logic [8:0] V_BR    = 9'b1111_1110_1;
    localparam logic [8:0] V_MEM   = 9'b0000_0001_0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h required %0h", nm, $time, got, exp);
        end
    endtask

    // Behavioural model: previous action, length of the current stall run, sticky error, event totals.
    int m_state = 0;
    int m_run   = 0;
    int m_err   = 0;
    int m_sc    = 0;
    int m_bc    = 0;

    function automatic int m_action(int prev);
        bit lu;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (mem_access && !dmem_ready) return 3;
        if (mem_branch && mem_z_flag) return 2;
        if (lu && prev != 1) return 1;
        return 0;
    endfunction

    function automatic logic [8:0] m_vec(int a, logic rst);
        if (rst) return V_RESET;
        case (a)
            3:       return V_MEM;
            2:       return V_BR;
            1:       return V_LD;
            default: return V_RUN;
        endcase
    endfunction

    always @(posedge clk) begin
        int a;
        a = m_action(m_state);
        if (reset) begin
            m_state = 0; m_run = 0; m_err = 0; m_sc = 0; m_bc = 0;
        end else begin
            m_state = a;
            if (a == 3) begin
                m_run++;
                if (m_run >= MT) m_err = 1;
            end else begin
                m_run = 0;
            end
            if (a == 3 || a == 1) m_sc = (m_sc + 1) % (1 << PW);
            if (a == 2) m_bc = (m_bc + 1) % (1 << PW);
        end
    end

    always @(negedge clk) begin
        #2;
        chk("ctrl_vec", 32'(dut_vec), 32'(m_vec(m_action(m_state), reset)));
        chk("state", 32'(state), 32'(m_state));
        chk("timeout_err", 32'(mem_timeout_err), 32'(m_err));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        chk("branch_flushes", 32'(branch_flushes), 32'(m_bc));
`endif
    end

    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic emr, input logic [4:0] rd,
                         input logic br, input logic z, input logic acc, input logic rdy);
        @(negedge clk);
        reset = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_mem_read = emr; ex_rd = rd; mem_branch = br; mem_z_flag = z;
        mem_access = acc; dmem_ready = rdy;
        #3;
    endtask

    task automatic idle(input logic r);
        drive(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic mstall(input logic r);
        drive(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int stall_left;
        reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; mem_branch = 1'b0; mem_z_flag = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b1;

        idle(1'b1);
        chk("lit_reset_vec", 32'(dut_vec), 32'(V_RESET));
        idle(1'b0);
        chk("lit_reset_state", 32'(state), 32'd0);
        chk("lit_reset_err", 32'(mem_timeout_err), 32'd0);
        chk("lit_idle_vec", 32'(dut_vec), 32'(V_RUN));

        // Load-use on rs1, held for a second cycle, then rd=x0.
        drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_ld_vec", 32'(dut_vec), 32'(V_LD));
        drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_ld_state", 32'(state), 32'd1);
        chk("lit_ld_once", 32'(dut_vec), 32'(V_RUN));
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_x0_vec", 32'(dut_vec), 32'(V_RUN));

        // Taken branch, not-taken branch, branch together with load-use.
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("lit_br_vec", 32'(dut_vec), 32'(V_BR));
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lit_br_state", 32'(state), 32'd2);
        chk("lit_nt_vec", 32'(dut_vec), 32'(V_RUN));
        drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("lit_br_ld_vec", 32'(dut_vec), 32'(V_BR));

        // Three-cycle memory wait then ready.
        for (int i = 1; i <= 3; i++) begin
            mstall(1'b0);
            chk("lit_mw_vec", 32'(dut_vec), 32'(V_MEM));
            if (i > 1) chk("lit_mw_state", 32'(state), 32'd3);
        end
        idle(1'b0);
        chk("lit_mw_done_state", 32'(state), 32'd3);
        chk("lit_mw_done_vec", 32'(dut_vec), 32'(V_RUN));
        chk("lit_mw_done_err", 32'(mem_timeout_err), 32'd0);

        // Memory wait hides a taken branch until the ready cycle.
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lit_mw_br_vec", 32'(dut_vec), 32'(V_MEM));
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("lit_mw_br_ready", 32'(dut_vec), 32'(V_BR));

        // Just under the limit twice in a row: the run counter must restart.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < MT - 1; i++) mstall(1'b0);
            idle(1'b0);
            chk("lit_short_err", 32'(mem_timeout_err), 32'd0);
        end

        // Timeout after MT consecutive stall cycles; sticky until reset.
        for (int i = 1; i <= 6; i++) begin
            mstall(1'b0);
            chk("lit_to_err", 32'(mem_timeout_err), 32'((i >= MT + 1) ? 1 : 0));
        end
        idle(1'b0);
        chk("lit_to_sticky", 32'(mem_timeout_err), 32'd1);
        idle(1'b0);
        chk("lit_to_sticky2", 32'(mem_timeout_err), 32'd1);
        idle(1'b1);
        idle(1'b0);
        chk("lit_to_cleared", 32'(mem_timeout_err), 32'd0);

        // Reset in the second memory-wait cycle.
        mstall(1'b0);
        mstall(1'b1);
        chk("lit_rst_mw_vec", 32'(dut_vec), 32'(V_RESET));
        idle(1'b0);
        chk("lit_rst_mw_state", 32'(state), 32'd0);
        chk("lit_rst_mw_err", 32'(mem_timeout_err), 32'd0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("lit_rst_mw_sc", 32'(stall_cycles), 32'd0);
        chk("lit_rst_mw_bc", 32'(branch_flushes), 32'd0);
`endif
        for (int i = 0; i < MT - 1; i++) mstall(1'b0);
        idle(1'b0);
        chk("lit_rst_cnt_cleared", 32'(mem_timeout_err), 32'd0);

        // Randomized traffic with stall bursts and occasional resets.
        stall_left = 0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            reset       = ($urandom_range(0, 99) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_rd       = 5'($urandom_range(0, 3));
            mem_branch  = ($urandom_range(0, 3) == 0);
            mem_z_flag  = 1'($urandom_range(0, 1));
            if (stall_left == 0 && $urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 7);
            if (stall_left > 0) begin
                mem_access = 1'b1;
                dmem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_access = 1'($urandom_range(0, 1));
                dmem_ready = 1'b1;
            end
        end

        @(negedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
